// File: rtl/writeback_cycle.sv
// writeback_cycle: final pipeline stage. Registers the memory-stage result,
// selects write data (ALU result, extended load, or PC+4) and drives the
// register-file write port. Also returns the combinational selected data of
// the current inputs as dm_data_bypass for forwarding.
//
// Optional feature macro: WB_RETIRE_COUNT_EN adds a 64-bit retire_count port
// counting accepted, non-misaligned instructions.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no entry held; write port idle
// COMMIT | entry captured last edge, presented on write port this cycle
// HOLD   | entry retained under stall; already written, port idle
module writeback_cycle #(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int FUNCT3_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mw_valid,
    input  logic                     mw_stall,
    input  logic                     mw_flush,
    input  logic                     rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] rf_write_addr,
    input  logic [1:0]               rf_write_data_sel,
    input  logic [XLEN-1:0]          alu_data_out,
    input  logic [XLEN-1:0]          dm_read_data,
    input  logic [FUNCT3_SIZE-1:0]   dm_load_type,
    input  logic [1:0]               dm_byte_offset,
    input  logic [XLEN-1:0]          PC_in,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic [XLEN-1:0]          dm_data_bypass,
    output logic                     wb_misaligned
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0]              retire_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [FUNCT3_SIZE-1:0] LT_LB  = FUNCT3_SIZE'(0);
    localparam logic [FUNCT3_SIZE-1:0] LT_LH  = FUNCT3_SIZE'(1);
    localparam logic [FUNCT3_SIZE-1:0] LT_LBU = FUNCT3_SIZE'(4);
    localparam logic [FUNCT3_SIZE-1:0] LT_LHU = FUNCT3_SIZE'(5);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t                   state_q, state_d;
    logic                     wb_en_q, wb_en_d;
    logic [REGISTER_SIZE-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]          wb_data_q, wb_data_d;
    logic                     wb_mis_q, wb_mis_d;

    logic [7:0]               load_byte;
    logic [15:0]              load_half;
    logic [XLEN-1:0]          load_data;
    logic [XLEN-1:0]          pc_plus4;
    logic [XLEN-1:0]          sel_data;
    logic                     misaligned;
    logic                     capture;

    // Byte/halfword lane pick and sign/zero extension of the loaded word.
    always_comb begin
        load_byte = 8'h00;
        load_half = dm_byte_offset[1] ? dm_read_data[31:16] : dm_read_data[15:0];
        case (dm_byte_offset)
            2'd0:    load_byte = dm_read_data[7:0];
            2'd1:    load_byte = dm_read_data[15:8];
            2'd2:    load_byte = dm_read_data[23:16];
            default: load_byte = dm_read_data[31:24];
        endcase
        case (dm_load_type)
            LT_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            LT_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
            LT_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
            LT_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = dm_read_data;   // LW and reserved encodings
        endcase
    end

    // Misalignment only matters for loads; byte loads can never be misaligned.
    always_comb begin
        misaligned = 1'b0;
        if (rf_write_data_sel == SEL_LOAD) begin
            case (dm_load_type)
                LT_LB, LT_LBU: misaligned = 1'b0;
                LT_LH, LT_LHU: misaligned = dm_byte_offset[0];
                default:       misaligned = (dm_byte_offset != 2'd0);
            endcase
        end
    end

    // Write-data mux; PC+4 wraps naturally at XLEN bits.
    always_comb begin
        pc_plus4 = PC_in + XLEN'(4);
        case (rf_write_data_sel)
            SEL_LOAD: sel_data = load_data;
            SEL_PC4:  sel_data = pc_plus4;
            default:  sel_data = alu_data_out;
        endcase
    end

    assign dm_data_bypass = sel_data;

    // Next-state and registered-output computation; flush beats stall beats capture.
    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        wb_mis_d  = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        capture   = 1'b0;
        if (mw_flush) begin
            state_d = IDLE;
        end else if (mw_stall) begin
            state_d = (state_q == IDLE) ? IDLE : HOLD;
        end else if (mw_valid) begin
            state_d   = COMMIT;
            capture   = 1'b1;
            wb_en_d   = rf_write_enable && (rf_write_addr != '0) && !misaligned;
            wb_mis_d  = misaligned;
            wb_addr_d = rf_write_addr;
            wb_data_d = sel_data;
        end else begin
            state_d = IDLE;
        end
    end

    // State and write-port registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wb_en_q   <= 1'b0;
            wb_mis_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            wb_mis_q  <= wb_mis_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign rf_writeback_enable = wb_en_q;
    assign rf_writeback_addr   = wb_addr_q;
    assign rf_writeback_data   = wb_data_q;
    assign wb_misaligned       = wb_mis_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retire_q, retire_d;

    // Misaligned loads never retire; x0 and non-writing instructions do.
    always_comb begin
        retire_d = retire_q;
        if (capture && !misaligned) begin
            retire_d = retire_q + 64'd1;
        end
    end

    // Retire counter register, wraps at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench for writeback_cycle: the stimulus pushes expected writes,
// a monitor pops and compares whenever the DUT presents a write or misalign.
module tb_writeback_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mw_valid = 1'b0, mw_stall = 1'b0, mw_flush = 1'b0;
    logic        rf_write_enable = 1'b0;
    logic [4:0]  rf_write_addr = '0;
    logic [1:0]  rf_write_data_sel = '0;
    logic [31:0] alu_data_out = '0, dm_read_data = '0, PC_in = '0;
    logic [2:0]  dm_load_type = '0;
    logic [1:0]  dm_byte_offset = '0;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [31:0] rf_writeback_data;
    logic [31:0] dm_data_bypass;
    logic        wb_misaligned;
`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retire_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    writeback_cycle dut (
        .clk                 (clk),
        .rst                 (rst),
        .mw_valid            (mw_valid),
        .mw_stall            (mw_stall),
        .mw_flush            (mw_flush),
        .rf_write_enable     (rf_write_enable),
        .rf_write_addr       (rf_write_addr),
        .rf_write_data_sel   (rf_write_data_sel),
        .alu_data_out        (alu_data_out),
        .dm_read_data        (dm_read_data),
        .dm_load_type        (dm_load_type),
        .dm_byte_offset      (dm_byte_offset),
        .PC_in               (PC_in),
        .rf_writeback_enable (rf_writeback_enable),
        .rf_writeback_addr   (rf_writeback_addr),
        .rf_writeback_data   (rf_writeback_data),
        .dm_data_bypass      (dm_data_bypass),
        .wb_misaligned       (wb_misaligned)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_count        (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write or misalign flag must match the queue head.
    always @(negedge clk) begin
        if (rst && (rf_writeback_enable || wb_misaligned)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got en=%0b mis=%0b addr=%0d expected nothing",
                         rf_writeback_enable, wb_misaligned, rf_writeback_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_misaligned", 64'(wb_misaligned), 64'(e.mis));
                check("wb_enable", 64'(rf_writeback_enable), 64'(!e.mis));
                check("wb_addr", 64'(rf_writeback_addr), 64'(e.addr));
                if (!e.mis) check("wb_data", 64'(rf_writeback_data), 64'(e.data));
            end
        end
    end

    // One cycle of stimulus; pushes an expectation when a write or misalign must follow.
    task automatic step(input logic v, input logic st, input logic fl, input logic we,
                        input logic [4:0] a, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc,
                        input logic [2:0] lt, input logic [1:0] off,
                        input logic exp_mis, input logic [31:0] exp_data);
        exp_t e;
        mw_valid = v; mw_stall = st; mw_flush = fl; rf_write_enable = we;
        rf_write_addr = a; rf_write_data_sel = sel; alu_data_out = alu;
        dm_read_data = dm; PC_in = pc; dm_load_type = lt; dm_byte_offset = off;
        #1;
        if (v && !exp_mis) check("bypass", 64'(dm_data_bypass), 64'(exp_data));
        if (v && !st && !fl && ((we && a != 5'd0) || exp_mis)) begin
            e.addr = a; e.data = exp_data; e.mis = exp_mis;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DM = 32'h80FF_7F01;

    initial begin
        #2;
        check("reset_enable", 64'(rf_writeback_enable), 64'd0);
        check("reset_addr", 64'(rf_writeback_addr), 64'd0);
        check("reset_data", 64'(rf_writeback_data), 64'd0);
        check("reset_mis", 64'(wb_misaligned), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
        check("reset_retire", retire_count, 64'd0);
`endif
        do_reset();

        // basic ALU write, then port goes quiet
        step(1, 0, 0, 1, 5'd5, 2'b00, 32'h0000_1234, 0, 0, 3'd0, 2'd0, 0, 32'h0000_1234);
        idle();
        check("enable_after_commit", 64'(rf_writeback_enable), 64'd0);
        check("addr_kept_idle", 64'(rf_writeback_addr), 64'd5);

        // load extraction
        step(1, 0, 0, 1, 5'd1, 2'b01, 0, DM, 0, 3'b000, 2'd3, 0, 32'hFFFF_FF80);
        step(1, 0, 0, 1, 5'd2, 2'b01, 0, DM, 0, 3'b100, 2'd3, 0, 32'h0000_0080);
        step(1, 0, 0, 1, 5'd3, 2'b01, 0, DM, 0, 3'b001, 2'd2, 0, 32'hFFFF_80FF);
        step(1, 0, 0, 1, 5'd4, 2'b01, 0, DM, 0, 3'b101, 2'd0, 0, 32'h0000_7F01);
        step(1, 0, 0, 1, 5'd6, 2'b01, 0, DM, 0, 3'b010, 2'd0, 0, 32'h80FF_7F01);
        step(1, 0, 0, 1, 5'd14, 2'b01, 0, DM, 0, 3'b000, 2'd0, 0, 32'h0000_0001);
        step(1, 0, 0, 1, 5'd15, 2'b01, 0, DM, 0, 3'b011, 2'd0, 0, 32'h80FF_7F01);
        step(1, 0, 0, 1, 5'd16, 2'b11, 32'hDEAD_BEEF, DM, 0, 3'd0, 2'd0, 0, 32'hDEAD_BEEF);

        // misaligned halfword, then aligned word
        step(1, 0, 0, 1, 5'd8, 2'b01, 0, DM, 0, 3'b001, 2'd1, 1, 32'h0);
        check("mis_during_commit", 64'(wb_misaligned), 64'd1);
        idle();
        check("mis_cleared", 64'(wb_misaligned), 64'd0);
        step(1, 0, 0, 1, 5'd17, 2'b01, 0, DM, 0, 3'b010, 2'd2, 1, 32'h0);
        step(1, 0, 0, 1, 5'd9, 2'b01, 0, DM, 0, 3'b010, 2'd0, 0, 32'h80FF_7F01);

        // stall holds entry; stalled inputs never written
        step(1, 0, 0, 1, 5'd7, 2'b00, 32'h0000_0077, 0, 0, 3'd0, 2'd0, 0, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 5'd10, 2'b00, 32'h0000_0099, 0, 0, 3'd0, 2'd0, 0, 32'h0000_0099);
            check("stall_enable", 64'(rf_writeback_enable), 64'd0);
            check("stall_addr", 64'(rf_writeback_addr), 64'd7);
            check("stall_data", 64'(rf_writeback_data), 64'h77);
        end
        idle();
        check("post_stall_addr", 64'(rf_writeback_addr), 64'd7);

        // x0 write suppressed; flush drops input
        step(1, 0, 0, 1, 5'd0, 2'b00, 32'h0000_00AA, 0, 0, 3'd0, 2'd0, 0, 32'h0000_00AA);
        step(1, 0, 1, 1, 5'd11, 2'b00, 32'h0000_00BB, 0, 0, 3'd0, 2'd0, 0, 32'h0000_00BB);
        idle();
        check("after_flush_addr", 64'(rf_writeback_addr), 64'd0);

        // PC+4 including wrap
        step(1, 0, 0, 1, 5'd13, 2'b10, 0, 0, 32'hFFFF_FFFC, 3'd0, 2'd0, 0, 32'h0000_0000);
        step(1, 0, 0, 1, 5'd18, 2'b10, 0, 0, 32'h0000_0100, 3'd0, 2'd0, 0, 32'h0000_0104);
        idle();

        // reset asserted while an entry is being committed
        mw_valid = 1; mw_stall = 0; mw_flush = 0; rf_write_enable = 1;
        rf_write_addr = 5'd12; rf_write_data_sel = 2'b00; alu_data_out = 32'h55;
        @(posedge clk);
        #1;
        check("commit_before_reset", 64'(rf_writeback_enable), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_enable", 64'(rf_writeback_enable), 64'd0);
        check("rst_addr", 64'(rf_writeback_addr), 64'd0);
        check("rst_data", 64'(rf_writeback_data), 64'd0);
        mw_valid = 0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle();

`ifdef WB_RETIRE_COUNT_EN
        do_reset();
        step(1, 0, 0, 1, 5'd1, 2'b00, 32'h1, 0, 0, 3'd0, 2'd0, 0, 32'h1);
        step(1, 0, 0, 1, 5'd0, 2'b00, 32'h2, 0, 0, 3'd0, 2'd0, 0, 32'h2);
        step(1, 0, 0, 0, 5'd2, 2'b00, 32'h3, 0, 0, 3'd0, 2'd0, 0, 32'h3);
        step(1, 0, 0, 1, 5'd3, 2'b01, 0, DM, 0, 3'b001, 2'd1, 1, 32'h0);
        step(1, 0, 0, 1, 5'd4, 2'b00, 32'h4, 0, 0, 3'd0, 2'd0, 0, 32'h4);
        step(1, 0, 0, 1, 5'd5, 2'b00, 32'h5, 0, 0, 3'd0, 2'd0, 0, 32'h5);
        idle();
        check("retire_count", retire_count, 64'd5);
`endif

        idle();
        idle();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
